sync_fifo_param: RTL and testbench

Parametrised single-clock synchronous FIFO with width, depth and threshold generics, registered read data with a valid strobe, a fill-level output, almost-full/almost-empty flags and sticky overflow/underflow error flags. It is the general-purpose buffering block between producer and consumer stages in the same clock domain. It replaces fixed 8x16 instances wherever a different width or depth, early back-pressure, or error visibility is needed.

---
 rtl/sync_fifo_param.sv | 86 ++++++++
 tb/tb_sync_fifo_param.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with level flags and sticky error flags
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] din,
    input  logic             rd_en,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_acc;
    logic             wr_acc;

    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside a read.
    assign rd_acc = rd_en && !empty;
    assign wr_acc = wr_en && (!full || rd_acc);

    // Flags decode the registered count directly, so they move on the same edge as count.
    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_LEVEL));
    assign almost_empty = (count <= CW'(AE_LEVEL));

    // Storage array: written on accepted writes only, never reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            dout_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky error flags; a new error event outranks a coincident clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow && !err_clr) || (wr_en && !wr_acc);
            underflow <= (underflow && !err_clr) || (rd_en && empty);
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - table-driven and randomized checks of sync_fifo_param against a queue model
module tb_sync_fifo_param;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 14;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             rd_en = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)
    ) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .err_clr(err_clr), .dout(dout), .dout_valid(dout_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit wr;
        int wdata;
        bit rd;
        bit clr;
        int e_count;
        int e_dout;
        int e_valid;
        int e_ovf;
        int e_unf;
    } vec_t;

    vec_t vecs[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural reference: a plain queue plus the observable registers.
    bit [WIDTH-1:0] mq[$];
    int m_dout = 0;
    int m_valid = 0;
    int m_ovf = 0;
    int m_unf = 0;

    function automatic void add(bit rst, bit wr, int wdata, bit rd, bit clr,
                                int c, int d, int v, int o, int u);
        vec_t t;
        t.rst = rst; t.wr = wr; t.wdata = wdata; t.rd = rd; t.clr = clr;
        t.e_count = c; t.e_dout = d; t.e_valid = v; t.e_ovf = o; t.e_unf = u;
        vecs.push_back(t);
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(string tag, int c, int d, int v, int o, int u);
        check({tag, " count"}, int'(count), c);
        check({tag, " full"}, int'(full), int'(c == DEPTH));
        check({tag, " empty"}, int'(empty), int'(c == 0));
        check({tag, " almost_full"}, int'(almost_full), int'(c >= AF));
        check({tag, " almost_empty"}, int'(almost_empty), int'(c <= AE));
        check({tag, " dout"}, int'(dout), d);
        check({tag, " dout_valid"}, int'(dout_valid), v);
        check({tag, " overflow"}, int'(overflow), o);
        check({tag, " underflow"}, int'(underflow), u);
    endtask

    task automatic model_step(bit rst, bit wr, bit [WIDTH-1:0] d, bit rd, bit clr);
        bit can_rd;
        bit can_wr;
        if (rst) begin
            mq.delete();
            m_dout = 0; m_valid = 0; m_ovf = 0; m_unf = 0;
        end else begin
            can_rd = rd && (mq.size() > 0);
            can_wr = wr && ((mq.size() < DEPTH) || can_rd);
            m_ovf = int'((m_ovf != 0 && !clr) || (wr && !can_wr));
            m_unf = int'((m_unf != 0 && !clr) || (rd && mq.size() == 0));
            m_valid = int'(can_rd);
            if (can_rd) m_dout = int'(mq.pop_front());
            if (can_wr) mq.push_back(d);
        end
    endtask

    task automatic apply(bit rst, bit wr, bit [WIDTH-1:0] d, bit rd, bit clr);
        reset = rst; wr_en = wr; din = d; rd_en = rd; err_clr = clr;
        model_step(rst, wr, d, rd, clr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset, fill, drain.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 1, i, 0, 0, i + 1, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) add(0, 0, 0, 1, 0, 15 - i, i, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0, 8'h0F, 0, 0, 0);
        // Wrap-around.
        for (int i = 0; i < 10; i++) add(0, 1, 8'h20 + i, 0, 0, i + 1, 8'h0F, 0, 0, 0);
        for (int i = 0; i < 10; i++) add(0, 0, 0, 1, 0, 9 - i, 8'h20 + i, 1, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 1, 8'h40 + i, 0, 0, i + 1, 8'h29, 0, 0, 0);
        for (int i = 0; i < 12; i++) add(0, 0, 0, 1, 0, 11 - i, 8'h40 + i, 1, 0, 0);
        // Full plus simultaneous read/write.
        for (int i = 0; i < 16; i++) add(0, 1, 8'h60 + i, 0, 0, i + 1, 8'h4B, 0, 0, 0);
        add(0, 1, 8'hAA, 1, 0, 16, 8'h60, 1, 0, 0);
        for (int i = 0; i < 15; i++) add(0, 0, 0, 1, 0, 15 - i, 8'h61 + i, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 8'hAA, 1, 0, 0);
        // Errors.
        add(0, 0, 0, 1, 0, 0, 8'hAA, 0, 0, 1);
        for (int i = 0; i < 16; i++) add(0, 1, 8'h80 + i, 0, 0, i + 1, 8'hAA, 0, 0, 1);
        add(0, 1, 8'hFF, 0, 0, 16, 8'hAA, 0, 1, 1);
        add(0, 0, 0, 0, 0, 16, 8'hAA, 0, 1, 1);
        add(0, 0, 0, 0, 1, 16, 8'hAA, 0, 0, 0);
        add(0, 1, 8'hEE, 0, 1, 16, 8'hAA, 0, 1, 0);
        add(0, 0, 0, 0, 1, 16, 8'hAA, 0, 0, 0);
        // Reset mid-operation at count 7 with a write pending.
        for (int i = 0; i < 9; i++) add(0, 0, 0, 1, 0, 15 - i, 8'h80 + i, 1, 0, 0);
        add(1, 1, 8'h55, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 8'hC3, 0, 0, 1, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 8'hC3, 1, 0, 0);
        // Empty with simultaneous read/write: write only, underflow sets.
        add(0, 1, 8'h3C, 1, 0, 1, 8'hC3, 0, 0, 1);
        add(0, 0, 0, 1, 0, 0, 8'h3C, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 8'h3C, 0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        foreach (vecs[k]) begin
            apply(vecs[k].rst, vecs[k].wr, WIDTH'(vecs[k].wdata), vecs[k].rd, vecs[k].clr);
            check_all($sformatf("vec%0d", k), vecs[k].e_count, vecs[k].e_dout,
                      vecs[k].e_valid, vecs[k].e_ovf, vecs[k].e_unf);
        end

        // Randomized traffic against the queue model, with phases biased toward full and empty.
        apply(1, 0, 0, 0, 0);
        check_all("rnd_reset", mq.size(), m_dout, m_valid, m_ovf, m_unf);
        for (int n = 0; n < 3000; n++) begin
            int wp;
            bit r_rst, r_wr, r_rd, r_clr;
            bit [WIDTH-1:0] r_d;
            wp    = ((n / 300) % 2 == 0) ? 75 : 30;
            r_wr  = ($urandom_range(99) < wp);
            r_rd  = ($urandom_range(99) < 100 - wp);
            r_clr = ($urandom_range(99) < 5);
            r_rst = ($urandom_range(999) < 3);
            r_d   = WIDTH'($urandom);
            apply(r_rst, r_wr, r_d, r_rd, r_clr);
            check_all($sformatf("rnd%0d", n), mq.size(), m_dout, m_valid, m_ovf, m_unf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
